hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Producer-side companion to the forwarding unit; sits in the ID stage of the 5-stage pipeline.
- Detects hazards that forwarding cannot resolve: load-use, and multi-cycle EX operations (mul/div).
- Drives hold and bubble controls into the PC, IF/ID, ID/EX and EX/MEM registers, so the forwarding unit only sees resolvable dependencies.
- Keeps a saturating count of stall cycles for performance debug.

Parameters:
- MC_LAT, 4, total EX-stage cycles of a multi-cycle op; legal range ≥2.
- CNT_W, 8, width of the stall-cycle statistic counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-low
- IF_ID_valid  in  1  IF/ID holds a real instruction
- IF_ID_op1  in  4  first source register of the instruction in decode
- IF_ID_op2  in  4  second source register of the instruction in decode
- ID_EX_op1  in  4  destination register of the instruction in EX
- ID_EX_memRead  in  1  instruction in EX is a load
- ID_EX_multiCycle  in  1  instruction in EX is mul/div
- pc_hold  out  1  PC keeps its value
- if_id_hold  out  1  IF/ID keeps its contents
- id_ex_hold  out  1  ID/EX keeps its contents
- id_ex_bubble  out  1  zero all control fields loaded into ID/EX
- ex_mem_bubble  out  1  zero all control fields loaded into EX/MEM
- mc_busy  out  1  multi-cycle op occupying EX
- stall_cycles  out  CNT_W  saturating count of cycles with pc_hold=1

Behaviour:
- State register: IDLE, BUSY; down-counter cnt, width ⌈log2(MC_LAT)⌉+1. All registers update on rising clk.
- Reset (rst=0 at a clock edge): state=IDLE, cnt=0, stall_cycles=0.
  - While rst=0, all hold/bubble outputs and mc_busy are forced to 0 combinationally.
  - Reset mid-BUSY aborts the stall immediately.
- Outputs are combinational from state, cnt and inputs. Zero latency: the hold takes effect in the same cycle as detection.
- mc_start = (state==IDLE) && ID_EX_multiCycle.
  - Asserts pc_hold, if_id_hold, id_ex_hold, ex_mem_bubble and mc_busy.
  - Loads cnt=MC_LAT-1 and moves to BUSY.
- BUSY, cnt>1:
  - Same four controls asserted, mc_busy=1; cnt decrements.
  - id_ex_bubble=0. Load-use is not evaluated.
- BUSY, cnt==1 (release cycle):
  - No holds and no bubbles, mc_busy=0. The op leaves EX at this edge.
  - Next state IDLE, cnt=0.
  - ID_EX_multiCycle still high in this cycle must not re-trigger.
- Net effect: a multi-cycle op holds for exactly MC_LAT-1 cycles and occupies EX for MC_LAT cycles.
- Load-use condition:
  - IF_ID_valid && ID_EX_memRead && ID_EX_op1!=0 && (ID_EX_op1==IF_ID_op1 || ID_EX_op1==IF_ID_op2).
  - Evaluated only when not mc_start and not (BUSY with cnt>1).
  - Response: pc_hold=1, if_id_hold=1, id_ex_bubble=1 for that cycle only; id_ex_hold=0, ex_mem_bubble=0.
  - State unchanged. The next cycle re-evaluates; the load is then in MEM and the forwarding unit covers it.
- Register 0 never causes a hazard.
- mc_start has priority over load-use. The two cannot coexist in practice, since a load is not a multi-cycle op.
- Back-to-back multi-cycle ops:
  - The second enters EX after the release edge and triggers mc_start in the following IDLE cycle.
  - No idle gap is required.
- stall_cycles increments by 1 on every edge where pc_hold=1 and rst=1; it holds at 2^CNT_W-1.

Test Plan:
- Reset: rst=0 for 2 cycles with ID_EX_multiCycle=1 -> all outputs 0, stall_cycles=0. After release, mc_start fires on the first cycle with rst=1.
- Load-use: ID_EX_memRead=1, ID_EX_op1=5, IF_ID_op2=5, valid=1 -> pc_hold=if_id_hold=id_ex_bubble=1 for exactly 1 cycle; stall_cycles=1.
- Reg-0 and no-match filtering: ID_EX_op1=0 matching IF_ID_op1=0, then ID_EX_op1=3 vs sources 4/6, then IF_ID_valid=0 -> no hold in any case.
- Multi-cycle, MC_LAT=4: ID_EX_multiCycle=1 at cycle T -> holds and ex_mem_bubble high T..T+2, low at T+3, mc_busy high T..T+2; stall_cycles=3.
- Back-to-back multi-cycle ops -> two 3-cycle hold windows separated by exactly 1 release cycle; no retrigger in either release cycle.
- Reset mid-BUSY (cnt=2) and saturation: CNT_W=2 with 5 stall cycles -> reset forces IDLE and outputs 0 next edge; counter stops at 3.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall interface: pipeline status into the stall unit, hold and
// bubble controls plus the stall statistic back out.
`timescale 1ns/1ps
interface hazard_stall_unit_if #(
    parameter int CNT_W = 8
);
    logic             IF_ID_valid;
    logic [3:0]       IF_ID_op1;
    logic [3:0]       IF_ID_op2;
    logic [3:0]       ID_EX_op1;
    logic             ID_EX_memRead;
    logic             ID_EX_multiCycle;
    logic             pc_hold;
    logic             if_id_hold;
    logic             id_ex_hold;
    logic             id_ex_bubble;
    logic             ex_mem_bubble;
    logic             mc_busy;
    logic [CNT_W-1:0] stall_cycles;

    // Pipeline side: supplies stage status, consumes the controls.
    modport master (
        output IF_ID_valid, IF_ID_op1, IF_ID_op2, ID_EX_op1,
               ID_EX_memRead, ID_EX_multiCycle,
        input  pc_hold, if_id_hold, id_ex_hold, id_ex_bubble,
               ex_mem_bubble, mc_busy, stall_cycles
    );

    // Stall unit side.
    modport slave (
        input  IF_ID_valid, IF_ID_op1, IF_ID_op2, ID_EX_op1,
               ID_EX_memRead, ID_EX_multiCycle,
        output pc_hold, if_id_hold, id_ex_hold, id_ex_bubble,
               ex_mem_bubble, mc_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard stall unit. Holds the front of the pipeline for load-use
// hazards (one cycle, bubble into ID/EX) and for multi-cycle EX ops
// (MC_LAT-1 cycles, bubble into EX/MEM). All controls are combinational so
// the stall lands in the cycle the hazard is seen.
//
//   state | meaning
//   IDLE  | no multi-cycle op in EX; load-use checked every cycle
//   BUSY  | multi-cycle op in EX; cnt counts down to the release cycle
`timescale 1ns/1ps
module hazard_stall_unit #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_stall_unit_if.slave   hz
);
    localparam int CW = $clog2(MC_LAT) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [CNT_W-1:0] stall_q;

    logic mc_start;
    logic busy_hold;
    logic load_use;
    logic src_match;
    logic pc_hold;
    logic if_id_hold;
    logic id_ex_hold;
    logic id_ex_bubble;
    logic ex_mem_bubble;
    logic mc_busy;

    // State, countdown and saturating stall statistic; reset aborts any stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            stall_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (pc_hold && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    // Hazard detection, control outputs and next state. The release cycle
    // (BUSY, cnt==1) holds nothing, so a still-high multiCycle there cannot
    // retrigger; the next op starts from IDLE one cycle later.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        mc_start      = 1'b0;
        busy_hold     = 1'b0;
        load_use      = 1'b0;
        pc_hold       = 1'b0;
        if_id_hold    = 1'b0;
        id_ex_hold    = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mc_busy       = 1'b0;
        src_match     = (hz.ID_EX_op1 == hz.IF_ID_op1) ||
                        (hz.ID_EX_op1 == hz.IF_ID_op2);

        if (rst) begin
            mc_start  = (state == IDLE) && hz.ID_EX_multiCycle;
            busy_hold = (state == BUSY) && (cnt > CW'(1));
            load_use  = !mc_start && !busy_hold && hz.IF_ID_valid &&
                        hz.ID_EX_memRead && (hz.ID_EX_op1 != 4'd0) && src_match;

            pc_hold       = mc_start || busy_hold || load_use;
            if_id_hold    = mc_start || busy_hold || load_use;
            id_ex_hold    = mc_start || busy_hold;
            ex_mem_bubble = mc_start || busy_hold;
            mc_busy       = mc_start || busy_hold;
            id_ex_bubble  = load_use;
        end

        case (state)
            IDLE: begin
                if (mc_start) begin
                    state_nx = BUSY;
                    cnt_nx   = CW'(MC_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt > CW'(1)) begin
                    cnt_nx = cnt - CW'(1);
                end else begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign hz.pc_hold       = pc_hold;
    assign hz.if_id_hold    = if_id_hold;
    assign hz.id_ex_hold    = id_ex_hold;
    assign hz.id_ex_bubble  = id_ex_bubble;
    assign hz.ex_mem_bubble = ex_mem_bubble;
    assign hz.mc_busy       = mc_busy;
    assign hz.stall_cycles  = stall_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a default instance (MC_LAT=4,
// CNT_W=8) and a CNT_W=2 instance fed the same stimulus for saturation.
`timescale 1ns/1ps
module tb_hazard_stall_unit;
    logic clk;
    logic rst;

    int n_checks;
    int n_fail;
    int exp_stall;

    // ctl bit order: pc_hold, if_id_hold, id_ex_hold, id_ex_bubble, ex_mem_bubble, mc_busy
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110100;
    localparam logic [5:0] C_MC   = 6'b111011;

    hazard_stall_unit_if #(.CNT_W(8)) bif ();
    hazard_stall_unit_if #(.CNT_W(2)) sif ();

    hazard_stall_unit #(.MC_LAT(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bif)
    );

    hazard_stall_unit #(.MC_LAT(4), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .hz  (sif)
    );

    assign sif.IF_ID_valid      = bif.IF_ID_valid;
    assign sif.IF_ID_op1        = bif.IF_ID_op1;
    assign sif.IF_ID_op2        = bif.IF_ID_op2;
    assign sif.ID_EX_op1        = bif.ID_EX_op1;
    assign sif.ID_EX_memRead    = bif.ID_EX_memRead;
    assign sif.ID_EX_multiCycle = bif.ID_EX_multiCycle;

    logic [5:0] ctl;
    assign ctl = {bif.pc_hold, bif.if_id_hold, bif.id_ex_hold,
                  bif.id_ex_bubble, bif.ex_mem_bubble, bif.mc_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bif.IF_ID_valid      = 1'b0;
        bif.IF_ID_op1        = 4'd0;
        bif.IF_ID_op2        = 4'd0;
        bif.ID_EX_op1        = 4'd0;
        bif.ID_EX_memRead    = 1'b0;
        bif.ID_EX_multiCycle = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        bif.ID_EX_multiCycle = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            #1;
            n_checks++;
            if (ctl !== C_NONE) begin
                n_fail++;
                $display("FAIL reset_ctl[%0d]: got %b expected %b", i, ctl, C_NONE);
            end
            n_checks++;
            if (bif.stall_cycles !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_stall[%0d]: got %0d expected 0", i, bif.stall_cycles);
            end
        end
        cyc();
        rst = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_MC) begin
            n_fail++;
            $display("FAIL reset_release_mc_start: got %b expected %b", ctl, C_MC);
        end
        rst = 1'b0;
        bif.ID_EX_multiCycle = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_NONE) begin
            n_fail++;
            $display("FAIL reset_forces_zero: got %b expected %b", ctl, C_NONE);
        end
        cyc();
        rst = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_NONE || bif.stall_cycles !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_abort: got ctl %b stall %0d expected %b stall 0",
                     ctl, bif.stall_cycles, C_NONE);
        end
        exp_stall = 0;
    endtask

    task automatic test_load_use();
        cyc();
        bif.IF_ID_valid   = 1'b1;
        bif.ID_EX_memRead = 1'b1;
        bif.ID_EX_op1     = 4'd5;
        bif.IF_ID_op1     = 4'd2;
        bif.IF_ID_op2     = 4'd5;
        #1;
        n_checks++;
        if (ctl !== C_LU) begin
            n_fail++;
            $display("FAIL load_use_op2: got %b expected %b", ctl, C_LU);
        end
        cyc();
        exp_stall++;
        bif.ID_EX_memRead = 1'b0;
        bif.ID_EX_op1     = 4'd0;
        #1;
        n_checks++;
        if (ctl !== C_NONE || bif.stall_cycles !== 8'(exp_stall)) begin
            n_fail++;
            $display("FAIL load_use_one_cycle: got ctl %b stall %0d expected %b stall %0d",
                     ctl, bif.stall_cycles, C_NONE, exp_stall);
        end
        cyc();
        bif.ID_EX_memRead = 1'b1;
        bif.ID_EX_op1     = 4'd7;
        bif.IF_ID_op1     = 4'd7;
        bif.IF_ID_op2     = 4'd1;
        #1;
        n_checks++;
        if (ctl !== C_LU) begin
            n_fail++;
            $display("FAIL load_use_op1: got %b expected %b", ctl, C_LU);
        end
        cyc();
        exp_stall++;
        clear_inputs();
        #1;
        n_checks++;
        if (ctl !== C_NONE || bif.stall_cycles !== 8'(exp_stall)) begin
            n_fail++;
            $display("FAIL load_use_op1_after: got ctl %b stall %0d expected %b stall %0d",
                     ctl, bif.stall_cycles, C_NONE, exp_stall);
        end
    endtask

    task automatic test_filter();
        // {valid, memRead, ID_EX_op1, IF_ID_op1, IF_ID_op2}
        logic [13:0] vec [4];
        vec[0] = {1'b1, 1'b1, 4'd0, 4'd0, 4'd9};
        vec[1] = {1'b1, 1'b1, 4'd3, 4'd4, 4'd6};
        vec[2] = {1'b0, 1'b1, 4'd5, 4'd5, 4'd5};
        vec[3] = {1'b1, 1'b0, 4'd5, 4'd5, 4'd5};
        for (int i = 0; i < 4; i++) begin
            cyc();
            {bif.IF_ID_valid, bif.ID_EX_memRead, bif.ID_EX_op1,
             bif.IF_ID_op1, bif.IF_ID_op2} = vec[i];
            #1;
            n_checks++;
            if (ctl !== C_NONE) begin
                n_fail++;
                $display("FAIL filter[%0d]: got %b expected %b", i, ctl, C_NONE);
            end
        end
        cyc();
        clear_inputs();
        #1;
        n_checks++;
        if (bif.stall_cycles !== 8'(exp_stall)) begin
            n_fail++;
            $display("FAIL filter_stall: got %0d expected %0d", bif.stall_cycles, exp_stall);
        end
    endtask

    task automatic test_multicycle();
        logic [5:0] exp;
        for (int i = 0; i < 5; i++) begin
            cyc();
            clear_inputs();
            bif.ID_EX_multiCycle = (i < 4);
            if (i == 1) begin
                bif.IF_ID_valid   = 1'b1;
                bif.ID_EX_memRead = 1'b1;
                bif.ID_EX_op1     = 4'd5;
                bif.IF_ID_op2     = 4'd5;
            end
            exp = (i < 3) ? C_MC : C_NONE;
            #1;
            n_checks++;
            if (ctl !== exp) begin
                n_fail++;
                $display("FAIL multicycle[%0d]: got %b expected %b", i, ctl, exp);
            end
        end
        exp_stall += 3;
        n_checks++;
        if (bif.stall_cycles !== 8'(exp_stall)) begin
            n_fail++;
            $display("FAIL multicycle_stall: got %0d expected %0d", bif.stall_cycles, exp_stall);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp;
        for (int i = 0; i < 9; i++) begin
            cyc();
            clear_inputs();
            bif.ID_EX_multiCycle = (i < 8);
            exp = (i < 7 && i != 3) ? C_MC : C_NONE;
            #1;
            n_checks++;
            if (ctl !== exp) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %b expected %b", i, ctl, exp);
            end
        end
        exp_stall += 6;
        n_checks++;
        if (bif.stall_cycles !== 8'(exp_stall)) begin
            n_fail++;
            $display("FAIL back_to_back_stall: got %0d expected %0d", bif.stall_cycles, exp_stall);
        end
    endtask

    task automatic test_reset_mid_busy_and_sat();
        int exp_sat;
        cyc();
        rst = 1'b0;
        clear_inputs();
        cyc();
        rst = 1'b1;
        #1;
        n_checks++;
        if (bif.stall_cycles !== 8'd0 || sif.stall_cycles !== 2'd0) begin
            n_fail++;
            $display("FAIL sat_init: got %0d/%0d expected 0/0", bif.stall_cycles, sif.stall_cycles);
        end
        exp_stall = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            bif.IF_ID_valid   = 1'b1;
            bif.ID_EX_memRead = 1'b1;
            bif.ID_EX_op1     = 4'd5;
            bif.IF_ID_op1     = 4'd5;
            #1;
            exp_sat = (exp_stall > 3) ? 3 : exp_stall;
            n_checks++;
            if (ctl !== C_LU || bif.stall_cycles !== 8'(exp_stall) ||
                sif.stall_cycles !== 2'(exp_sat)) begin
                n_fail++;
                $display("FAIL sat_load_use[%0d]: got ctl %b stall %0d sat %0d expected %b %0d %0d",
                         k, ctl, bif.stall_cycles, sif.stall_cycles, C_LU, exp_stall, exp_sat);
            end
            exp_stall++;
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            clear_inputs();
            bif.ID_EX_multiCycle = 1'b1;
            #1;
            exp_sat = (exp_stall > 3) ? 3 : exp_stall;
            n_checks++;
            if (ctl !== C_MC || bif.stall_cycles !== 8'(exp_stall) ||
                sif.stall_cycles !== 2'(exp_sat)) begin
                n_fail++;
                $display("FAIL sat_mc[%0d]: got ctl %b stall %0d sat %0d expected %b %0d %0d",
                         i, ctl, bif.stall_cycles, sif.stall_cycles, C_MC, exp_stall, exp_sat);
            end
            exp_stall++;
        end
        cyc();
        rst = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_NONE || bif.stall_cycles !== 8'(exp_stall) || sif.stall_cycles !== 2'd3) begin
            n_fail++;
            $display("FAIL mid_busy_reset: got ctl %b stall %0d sat %0d expected %b %0d 3",
                     ctl, bif.stall_cycles, sif.stall_cycles, C_NONE, exp_stall);
        end
        cyc();
        rst = 1'b1;
        bif.ID_EX_multiCycle = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_NONE || bif.stall_cycles !== 8'd0 || sif.stall_cycles !== 2'd0) begin
            n_fail++;
            $display("FAIL after_mid_busy_reset: got ctl %b stall %0d sat %0d expected %b 0 0",
                     ctl, bif.stall_cycles, sif.stall_cycles, C_NONE);
        end
        exp_stall = 0;
        cyc();
        bif.ID_EX_multiCycle = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_MC) begin
            n_fail++;
            $display("FAIL restart_after_reset: got %b expected %b", ctl, C_MC);
        end
        cyc();
        rst = 1'b0;
        clear_inputs();
        cyc();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_stall = 0;
        rst       = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_filter();
        test_multicycle();
        test_back_to_back();
        test_reset_mid_busy_and_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
